// File: rtl/group_sched_pkg.sv
// Shared types and width helpers for the group-spike scheduler and the SNN top controller.
package group_sched_pkg;

    localparam int G_NUM_DEF   = 4;
    localparam int SRC_NUM_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // A one-bit vector still needs a one-bit index port.
    function automatic int idx_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Priority encoder: picks the highest set bit (msb_first=1) or the lowest (msb_first=0).
module onehot_prio_enc
    import group_sched_pkg::*;
#(
    parameter  int W     = 8,
    localparam int IDX_W = idx_width(W)
) (
    input  logic [W-1:0]     vec,
    input  logic             msb_first,
    output logic [W-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        idx = '0;
        any = |vec;
        if (msb_first) begin
            for (int i = 0; i < W; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = W - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
        onehot = any ? (W'(1) << idx) : '0;
    end

endmodule

// File: rtl/group_spike_scheduler.sv
// Loads a group-spike code word and issues one one-hot synapse enable per accepted spike.
module group_spike_scheduler
    import group_sched_pkg::*;
#(
    parameter  int G_NUM   = G_NUM_DEF,
    parameter  int SRC_NUM = SRC_NUM_DEF,
    localparam int W       = SRC_NUM * G_NUM,
    localparam int IDX_W   = idx_width(W),
    localparam int CNT_W   = cnt_width(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [W-1:0]     code_in,
    input  logic             msb_first,
    input  logic             load_valid,
    output logic             load_ready,
    output logic [W-1:0]     syn_en,
    output logic [IDX_W-1:0] syn_idx,
    output logic             syn_valid,
    input  logic             syn_ready,
    output logic [CNT_W-1:0] spike_tot,
    output logic [CNT_W-1:0] issued_cnt,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [W-1:0]     pending_q, pending_d;
    logic             order_q, order_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] load_pop;

    logic [W-1:0]     sel_onehot;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;

    onehot_prio_enc #(.W(W)) u_enc (
        .vec       (pending_q),
        .msb_first (order_q),
        .onehot    (sel_onehot),
        .idx       (sel_idx),
        .any       (sel_any)
    );

    always_comb begin
        load_pop = '0;
        for (int i = 0; i < W; i++) begin
            load_pop = load_pop + CNT_W'(code_in[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the comb blocks use blocking ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            order_q   <= 1'b0;
            tot_q     <= '0;
            issued_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            order_q   <= order_d;
            tot_q     <= tot_d;
            issued_q  <= issued_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        order_d   = order_q;
        tot_d     = tot_q;
        issued_d  = issued_q;
        if (flush) begin
            state_d   = IDLE;
            pending_d = '0;
            tot_d     = '0;
            issued_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        pending_d = code_in;
                        order_d   = msb_first;
                        tot_d     = load_pop;
                        issued_d  = '0;
                        state_d   = (code_in != '0) ? SCAN : DONE;
                    end
                end
                SCAN: begin
                    if (syn_ready) begin
                        pending_d = pending_q & ~sel_onehot;
                        issued_d  = issued_q + CNT_W'(1);
                        if (pending_d == '0) state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        load_ready = (state_q == IDLE);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        syn_valid  = (state_q == SCAN) && sel_any;
        syn_en     = syn_valid ? sel_onehot : '0;
        syn_idx    = syn_valid ? sel_idx : '0;
    end

    assign spike_tot  = tot_q;
    assign issued_cnt = issued_q;

endmodule

// File: tb/tb_group_spike_scheduler.sv
// Scoreboard bench: a queue-based spike-order model feeds a monitor that checks every offered spike.
module tb_group_spike_scheduler;
    import group_sched_pkg::*;

    localparam int W     = G_NUM_DEF * SRC_NUM_DEF;
    localparam int IDX_W = idx_width(W);
    localparam int CNT_W = cnt_width(W);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [W-1:0]     code_in;
    logic             msb_first;
    logic             load_valid;
    logic             load_ready;
    logic [W-1:0]     syn_en;
    logic [IDX_W-1:0] syn_idx;
    logic             syn_valid;
    logic             syn_ready;
    logic [CNT_W-1:0] spike_tot;
    logic [CNT_W-1:0] issued_cnt;
    logic             busy;
    logic             done;

    group_spike_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .code_in    (code_in),
        .msb_first  (msb_first),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .syn_en     (syn_en),
        .syn_idx    (syn_idx),
        .syn_valid  (syn_valid),
        .syn_ready  (syn_ready),
        .spike_tot  (spike_tot),
        .issued_cnt (issued_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int issued;
    } spike_t;

    spike_t exp_spike_q[$];
    int     exp_tot_q[$];
    int     n_total = 0;
    int     n_pass  = 0;
    int     mon_tot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference order: list the set bits, lowest first, reversed for msb-first scans.
    function automatic void model_push(input logic [W-1:0] code, input logic msb);
        int order[$];
        for (int i = 0; i < W; i++) begin
            if (code[i]) begin
                if (msb) order.push_front(i);
                else     order.push_back(i);
            end
        end
        foreach (order[k]) exp_spike_q.push_back('{idx: order[k], issued: k});
        exp_tot_q.push_back(order.size());
    endfunction

    function automatic bit ready_at(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return $urandom_range(0, 3) != 0;
            default: return !(cyc == 2 || cyc == 3);
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (syn_valid) begin
                if (exp_spike_q.size() == 0) begin
                    check("unexpected_spike", 32'(syn_valid), 32'd0);
                end else begin
                    check("syn_idx", 32'(syn_idx), exp_spike_q[0].idx);
                    check("syn_en", 32'(syn_en), 32'd1 << exp_spike_q[0].idx);
                    check("issued_cnt_scan", 32'(issued_cnt), exp_spike_q[0].issued);
                    if (syn_ready) void'(exp_spike_q.pop_front());
                end
            end else begin
                check("idle_syn_outputs", 32'({syn_en, syn_idx}), 32'd0);
            end
            if (done) begin
                if (exp_tot_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_tot = exp_tot_q.pop_front();
                    check("done_spike_tot", 32'(spike_tot), mon_tot);
                    check("done_issued_cnt", 32'(issued_cnt), mon_tot);
                    check("done_spikes_left", exp_spike_q.size(), 32'd0);
                end
            end
        end
    end

    task automatic wait_load_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (load_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("load_ready_timeout", 32'(load_ready), 32'd1);
    endtask

    task automatic do_load(input logic [W-1:0] code, input bit msb, input int mode, input bit poke);
        bit ok;
        bit r;
        int k, acc, last_acc, done_cyc;
        wait_load_ready(ok);
        if (!ok) return;
        code_in    = code;
        msb_first  = msb;
        load_valid = 1'b1;
        k          = $countones(code);
        model_push(code, msb);
        @(posedge clk); #1;
        load_valid = poke;
        code_in    = W'($urandom);
        msb_first  = 1'($urandom);
        check("busy_after_load", 32'(busy), 32'd1);
        check("load_ready_low", 32'(load_ready), 32'd0);
        acc = 0; last_acc = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            r = ready_at(mode, cyc);
            syn_ready = r;
            if (acc < k && r) begin
                acc++;
                last_acc = cyc;
            end
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            load_valid = poke;
            code_in    = W'($urandom);
        end
        check("done_cycle", done_cyc, (k == 0) ? 1 : last_acc + 1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        syn_ready  = 1'b0;
        check("load_ready_back", 32'(load_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("tot_hold", 32'(spike_tot), k);
        check("issued_hold", 32'(issued_cnt), k);
    endtask

    task automatic do_flush_test;
        bit ok;
        wait_load_ready(ok);
        if (!ok) return;
        code_in    = 8'h0F;
        msb_first  = 1'b0;
        load_valid = 1'b1;
        model_push(8'h0F, 1'b0);
        @(posedge clk); #1;
        load_valid = 1'b0;
        syn_ready  = 1'b1;
        @(posedge clk); #1;
        flush = 1'b1;
        exp_spike_q.delete();
        exp_tot_q.delete();
        @(posedge clk); #1;
        flush     = 1'b0;
        syn_ready = 1'b0;
        check("flush_load_ready", 32'(load_ready), 32'd1);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_spike_tot", 32'(spike_tot), 32'd0);
        check("flush_issued_cnt", 32'(issued_cnt), 32'd0);
        check("flush_syn_valid", 32'(syn_valid), 32'd0);
        do_load(8'h0F, 1'b1, 0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_syn_valid"}, 32'(syn_valid), 32'd0);
        check({tag, "_syn_en_idx"}, 32'({syn_en, syn_idx}), 32'd0);
        check({tag, "_busy_done"}, 32'({busy, done}), 32'd0);
        check({tag, "_counters"}, 32'({spike_tot, issued_cnt}), 32'd0);
        check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    endtask

    task automatic do_async_reset_test;
        bit ok;
        wait_load_ready(ok);
        if (!ok) return;
        code_in    = 8'hFF;
        msb_first  = 1'b1;
        load_valid = 1'b1;
        model_push(8'hFF, 1'b1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        syn_ready  = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        exp_spike_q.delete();
        exp_tot_q.delete();
        #1;
        check_reset_values("async_rst");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        syn_ready = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] rcode;
        rst        = 1'b1;
        flush      = 1'b0;
        load_valid = 1'b0;
        syn_ready  = 1'b0;
        code_in    = '0;
        msb_first  = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_busy", 32'(busy), 32'd0);

        do_load(8'hA1, 1'b1, 0, 1'b0);
        do_load(8'hA1, 1'b0, 0, 1'b0);
        do_load(8'hFF, 1'b1, 2, 1'b0);
        do_load(8'h00, 1'b0, 0, 1'b0);
        do_flush_test();
        do_load(8'h3C, 1'b0, 1, 1'b1);
        do_async_reset_test();

        for (int n = 0; n < 40; n++) begin
            rcode = W'($urandom);
            if ($urandom_range(0, 7) == 0) rcode = '0;
            do_load(rcode, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        check("queues_empty", exp_spike_q.size() + exp_tot_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/group_spike_scheduler.md
# group_spike_scheduler

Parametrised group-spike scheduler for the SNN core's synapse-accumulate phase. It accepts one group-spike code word covering SRC_NUM spike sources of G_NUM groups each. It then issues one one-hot synapse enable per accepted handshake for every set bit, in a selectable priority order. It sits between the spike-code SRAM reader and the synaptic accumulator, and reports spike totals plus a completion pulse to the top-level controller.

## Interface
- G_NUM, 4, groups per source
- SRC_NUM, 2, number of spike sources
- W (derived), SRC_NUM*G_NUM, code width
- IDX_W (derived), $clog2(W), index width
- CNT_W (derived), $clog2(W+1), count width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort, highest priority after rst
- code_in  in  W  concatenated codes {src0, src1, …}; src0 occupies the MSBs
- msb_first  in  1  scan order, sampled at load: 1 = bit W-1 down to bit 0, 0 = bit 0 up
- load_valid  in  1  code_in valid
- load_ready  out  1  high only in IDLE
- syn_en  out  W  one-hot enable of the current spike; 0 when syn_valid=0
- syn_idx  out  IDX_W  binary index of the syn_en bit; 0 when syn_valid=0
- syn_valid  out  1  a spike is being offered
- syn_ready  in  1  accumulator accepts the spike
- spike_tot  out  CNT_W  popcount of the loaded code
- issued_cnt  out  CNT_W  spikes accepted since load
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at the end of the scan

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - load_ready=1.
  - On load_valid: pending is loaded with code_in, order with msb_first, spike_tot with popcount(code_in), and issued_cnt is cleared.
  - Next state is SCAN if code_in≠0, otherwise DONE.
- SCAN:
  - syn_valid=1.
  - syn_en and syn_idx select the highest-priority set bit of pending in the latched order. Selection is combinational from registers.
  - On syn_valid&&syn_ready: the selected bit is cleared in pending and issued_cnt increments.
  - If the accepted bit was the last one set, next state is DONE.
  - If syn_ready=0, everything holds and syn_en/syn_idx stay stable.
- DONE: done=1 for exactly one cycle, then the block returns to IDLE. spike_tot and issued_cnt hold until the next load.
- flush (any state): next state is IDLE, pending, spike_tot and issued_cnt are cleared, and no done pulse is issued.
- Width rules:
  - issued_cnt never exceeds spike_tot.
  - The counters are CNT_W wide, so W=2^k is representable without wrap.
  - The bit index of src s, group g is (SRC_NUM-1-s)*G_NUM + g.

## Timing
- Reset (rst high, asynchronous): state=IDLE, and pending, spike_tot, issued_cnt, syn_en, syn_idx, syn_valid, busy and done are all 0. load_ready=1.
- Load accepted at edge T:
  - syn_valid is first high in cycle T+1.
  - With syn_ready held high, k spikes are issued in cycles T+1..T+k.
  - done is high in T+k+1, and load_ready returns in T+k+2.
- Zero-code load at T: done is high in T+1, syn_valid never rises, and spike_tot=0.
- load_valid while not IDLE is ignored, and code_in is not sampled.
- flush and syn_ready in the same cycle: flush wins, so the spike is not counted.
- rst asserted mid-SCAN forces the reset values immediately, without waiting for a clock edge.

## Structure
- Package group_sched_pkg holds:
  - the state enum (IDLE/SCAN/DONE);
  - width helper functions for IDX_W/CNT_W;
  - the default G_NUM/SRC_NUM constants, shared with the SNN top state controller.
- Sub-module onehot_prio_enc, parameter W, inputs vec and msb_first, outputs onehot, idx and any. The scheduler instantiates it on pending.
- Popcount is implemented inline in the load path.

## Test plan
- Reset: assert rst mid-cycle -> all outputs 0 and load_ready=1 without a clock edge; after release, busy=0.
- MSB-first scan: code_in=8'hA1, msb_first=1, syn_ready=1 -> syn_en 8'h80/8'h20/8'h01 with syn_idx 7/5/0 in T+1..T+3; spike_tot=3; done at T+4; issued_cnt=3.
- LSB-first scan: same code, msb_first=0 -> syn_en 8'h01/8'h20/8'h80 with syn_idx 0/5/7.
- Backpressure: code_in=8'hFF with syn_ready low in cycles 2–3 -> syn_en held at 8'h40 and issued_cnt at 1 while stalled; all 8 spikes still issue in order; done once.
- Zero code: code_in=0 -> done at T+1, syn_valid never high, spike_tot=0.
- Flush: code_in=8'h0F, flush in the cycle after the first accept -> IDLE next cycle, no done pulse, counters 0, and a new load is accepted immediately. Also cover the case where load_valid arrives while busy and is ignored.
